pl_fetch_queue: RTL and testbench

//   Parametrised fetch front end for the pipelined RV32 core. Owns the PC register and a

---
 rtl/pl_fetch_queue.sv | 106 ++++++++++
 tb/tb_pl_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pl_fetch_queue.sv
// Fetch front end: owns the PC and a circular queue of {pc, instr} entries between
// instruction memory and decode. Fetch runs ahead of decode stalls; a redirect from
// execute flushes every queued entry and restarts fetch at the (halfword-aligned) target.
module pl_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [XLEN-1:0]         imem_addr,
  output logic                    imem_req,
  input  logic [31:0]             imem_rdata,
  input  logic                    halt,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    deq,
  output logic                    out_valid,
  output logic [31:0]             out_instr,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_pcplus4,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] Four     = XLEN'(4);
  localparam logic [31:0]     Nop      = 32'h0000_0013;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push, pop;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  // Handshake: redirect suppresses both push and pop; a full queue may push while popping.
  always_comb begin
    out_valid = (count_q != '0);
    pop       = deq & out_valid & ~redirect;
    push      = ~reset & ~redirect & ~halt & ((count_q != DepthCnt) | pop);
    imem_req  = push;
    imem_addr = pc_q;
  end

  // Next-state for PC, pointers and occupancy; redirect clears the queue.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = {redirect_pc[XLEN-1:1], 1'b0};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + Four;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Head presentation; an empty queue shows a nop to decode.
  always_comb begin
    out_pc      = pc_mem_q[rd_ptr_q];
    out_pcplus4 = out_pc + Four;
    out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : Nop;
    count       = count_q;
  end

endmodule

// File: tb/tb_pl_fetch_queue.sv
// Bench for pl_fetch_queue: directed scenarios on a DEPTH=4 instance and a randomized
// scoreboard run on a DEPTH=2 instance.
module tb_pl_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction memory content as a pure function of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) + 32'h1;
  endfunction

  // DEPTH=4 instance
  logic        reset4, halt4, redirect4, deq4;
  logic [31:0] rpc4, addr4, rdata4, instr4, pc4, pcp4;
  logic        req4, valid4;
  logic [2:0]  count4;
  assign rdata4 = instr_of(addr4);

  pl_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut4 (
    .clk(clk), .reset(reset4), .imem_addr(addr4), .imem_req(req4), .imem_rdata(rdata4),
    .halt(halt4), .redirect(redirect4), .redirect_pc(rpc4), .deq(deq4),
    .out_valid(valid4), .out_instr(instr4), .out_pc(pc4), .out_pcplus4(pcp4),
    .count(count4)
  );

  // DEPTH=2 instance
  logic        reset2, halt2, redirect2, deq2;
  logic [31:0] rpc2, addr2, rdata2, instr2, pc2, pcp2;
  logic        req2, valid2;
  logic [1:0]  count2;
  assign rdata2 = instr_of(addr2);

  pl_fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h0)) u_dut2 (
    .clk(clk), .reset(reset2), .imem_addr(addr2), .imem_req(req2), .imem_rdata(rdata2),
    .halt(halt2), .redirect(redirect2), .redirect_pc(rpc2), .deq(deq2),
    .out_valid(valid2), .out_instr(instr2), .out_pc(pc2), .out_pcplus4(pcp2),
    .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset4 = 1; halt4 = 0; redirect4 = 0; deq4 = 0; rpc4 = 0;
    tick();
    reset4 = 0;
    #1;
    total++; if (count4 !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count4); end
    total++; if (valid4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid4); end
    total++; if (instr4 !== 32'h13) begin bad++; $display("FAIL reset_nop got=%h exp=00000013", instr4); end
    total++; if (addr4 !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr4); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      total++; if (req4 !== 1'b1) begin bad++; $display("FAIL fill_req[%0d] got=%b exp=1", i, req4); end
      total++;
      if (addr4 !== 32'(4 * i)) begin bad++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, addr4, 4 * i); end
      tick();
    end
    #1;
    total++; if (count4 !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count4); end
    total++; if (req4 !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", req4); end
    total++; if (addr4 !== 32'h10) begin bad++; $display("FAIL full_addr got=%h exp=10", addr4); end
    total++;
    if (instr4 !== instr_of(32'h0)) begin bad++; $display("FAIL full_head_instr got=%h exp=%h", instr4, instr_of(32'h0)); end
  endtask

  task automatic test_back_to_back();
    deq4 = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (pc4 !== 32'(4 * i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, pc4, 4 * i); end
      total++;
      if (pcp4 !== 32'(4 * i + 4)) begin bad++; $display("FAIL b2b_pcplus4[%0d] got=%h exp=%h", i, pcp4, 4 * i + 4); end
      total++; if (count4 !== 3'd4) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, count4); end
      total++; if (req4 !== 1'b1) begin bad++; $display("FAIL b2b_req[%0d] got=%b exp=1", i, req4); end
      tick();
    end
    deq4 = 0;
  endtask

  task automatic test_redirect();
    // Pop once with fetch halted to reach count=3.
    deq4 = 1; halt4 = 1;
    tick();
    deq4 = 0; halt4 = 0;
    #1;
    total++; if (count4 !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", count4); end
    redirect4 = 1; rpc4 = 32'h101;
    tick();
    redirect4 = 0;
    #1;
    total++; if (count4 !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", count4); end
    total++; if (valid4 !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", valid4); end
    total++; if (instr4 !== 32'h13) begin bad++; $display("FAIL redir_nop got=%h exp=00000013", instr4); end
    total++; if (addr4 !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h exp=100", addr4); end
    tick();
    total++; if (pc4 !== 32'h100) begin bad++; $display("FAIL redir_head_pc got=%h exp=100", pc4); end
    total++; if (pcp4 !== 32'h104) begin bad++; $display("FAIL redir_head_pcp4 got=%h exp=104", pcp4); end
    total++;
    if (instr4 !== instr_of(32'h100)) begin bad++; $display("FAIL redir_head_instr got=%h exp=%h", instr4, instr_of(32'h100)); end
  endtask

  task automatic test_redirect_deq();
    tick();
    total++; if (count4 !== 3'd2) begin bad++; $display("FAIL rdq_pre_count got=%0d exp=2", count4); end
    redirect4 = 1; deq4 = 1; rpc4 = 32'h200;
    tick();
    redirect4 = 0; deq4 = 0;
    #1;
    total++; if (count4 !== 3'd0) begin bad++; $display("FAIL rdq_count got=%0d exp=0", count4); end
    total++; if (valid4 !== 1'b0) begin bad++; $display("FAIL rdq_valid got=%b exp=0", valid4); end
    tick();
    total++; if (count4 !== 3'd1) begin bad++; $display("FAIL rdq_count2 got=%0d exp=1", count4); end
    total++; if (pc4 !== 32'h200) begin bad++; $display("FAIL rdq_head got=%h exp=200", pc4); end
  endtask

  task automatic test_halt_reset();
    tick();
    tick();
    total++; if (count4 !== 3'd3) begin bad++; $display("FAIL hr_pre_count got=%0d exp=3", count4); end
    halt4 = 1;
    #1;
    total++; if (req4 !== 1'b0) begin bad++; $display("FAIL halt_req got=%b exp=0", req4); end
    tick();
    total++; if (count4 !== 3'd3) begin bad++; $display("FAIL halt_count got=%0d exp=3", count4); end
    total++; if (addr4 !== 32'h20C) begin bad++; $display("FAIL halt_addr got=%h exp=20c", addr4); end
    reset4 = 1;
    tick();
    reset4 = 0; halt4 = 0;
    #1;
    total++; if (count4 !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", count4); end
    total++; if (addr4 !== 32'h0) begin bad++; $display("FAIL mid_reset_addr got=%h exp=0", addr4); end
    total++; if (valid4 !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", valid4); end
  endtask

  // Random deq/halt/occasional redirect on DEPTH=2 against a queue-of-PCs model.
  task automatic test_random_depth2();
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        v, p_pop, p_push;
    int          lost;
    reset2 = 1; halt2 = 0; redirect2 = 0; deq2 = 0; rpc2 = 0;
    tick();
    reset2 = 0;
    exp_pc = 32'h0;
    lost = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      deq2      = ($urandom_range(0, 2) != 0);
      halt2     = ($urandom_range(0, 4) == 0);
      redirect2 = ($urandom_range(0, 39) == 0);
      rpc2      = $urandom & 32'h0000_FFFF;
      #1;
      v      = (exp_q.size() != 0);
      p_pop  = deq2 && v && !redirect2;
      p_push = !redirect2 && !halt2 && (exp_q.size() < 2 || p_pop);
      total++;
      if (count2 !== 2'(exp_q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", cyc, count2, exp_q.size()); end
      total++;
      if (count2 > 2'd2) begin bad++; $display("FAIL rnd_count_bound[%0d] got=%0d max=2", cyc, count2); end
      total++; if (valid2 !== v) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, valid2, v); end
      total++; if (addr2 !== exp_pc) begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", cyc, addr2, exp_pc); end
      total++; if (req2 !== p_push) begin bad++; $display("FAIL rnd_req[%0d] got=%b exp=%b", cyc, req2, p_push); end
      if (v) begin
        total++; if (pc2 !== exp_q[0]) begin bad++; $display("FAIL rnd_head_pc[%0d] got=%h exp=%h", cyc, pc2, exp_q[0]); end
        total++;
        if (instr2 !== instr_of(exp_q[0])) begin bad++; $display("FAIL rnd_head_instr[%0d] got=%h exp=%h", cyc, instr2, instr_of(exp_q[0])); end
        total++;
        if (pcp2 !== exp_q[0] + 32'd4) begin bad++; $display("FAIL rnd_pcplus4[%0d] got=%h exp=%h", cyc, pcp2, exp_q[0] + 32'd4); end
      end else begin
        total++; if (instr2 !== 32'h13) begin bad++; $display("FAIL rnd_nop[%0d] got=%h exp=00000013", cyc, instr2); end
      end
      if (redirect2) begin
        lost += exp_q.size();
        exp_q.delete();
        exp_pc = {rpc2[31:1], 1'b0};
      end else begin
        if (p_pop) void'(exp_q.pop_front());
        if (p_push) begin
          exp_q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
      tick();
    end
    redirect2 = 0; deq2 = 0; halt2 = 0;
  endtask

  initial begin
    reset2 = 1; halt2 = 0; redirect2 = 0; deq2 = 0; rpc2 = 0;
    reset4 = 1; halt4 = 0; redirect4 = 0; deq4 = 0; rpc4 = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_redirect();
    test_redirect_deq();
    test_halt_reset();
    test_random_depth2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
